// File: rtl/fb_ddram_writer.sv
// Packs a 32bpp pixel stream into 64-bit words and writes them to the framebuffer
// in fixed-length DDRAM bursts, wrapping the address at the end of each frame.
`timescale 1ns/1ps
module fb_ddram_writer #(
    parameter logic [28:0] BASE_WADDR  = 29'h0600_0000,
    parameter int unsigned FRAME_WORDS = 460800,
    parameter int unsigned BURST       = 8,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    input  logic        pix_sof,
    input  logic        ddr_busy,
    output logic [7:0]  ddr_burstcnt,
    output logic [28:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_be,
    output logic        ddr_we,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PIX_W  = $clog2(2 * FRAME_WORDS);
    localparam int unsigned BEAT_W = $clog2(BURST + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(2 * FRAME_WORDS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [28:0]       END_WADDR = BASE_WADDR + 29'(FRAME_WORDS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              synced_q, synced_d;
    logic              half_vld_q, half_vld_d;
    logic [31:0]       half_q, half_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [28:0]       cur_waddr_q, cur_waddr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              ddr_we_q, ddr_we_d;
    logic [7:0]        ddr_burstcnt_q, ddr_burstcnt_d;
    logic [28:0]       ddr_addr_q, ddr_addr_d;
    logic [63:0]       ddr_din_q, ddr_din_d;
    logic              frame_done_q, frame_done_d;
    logic              sof_err_q, sof_err_d;
    logic              pix_ready_q, pix_ready_d;

    logic [63:0] fifo_mem [FIFO_DEPTH];
    logic        push, pop;
    logic [63:0] push_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d        = state_q;
        synced_d       = synced_q;
        half_vld_d     = half_vld_q;
        half_d         = half_q;
        pix_cnt_d      = pix_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_count_d   = fifo_count_q;
        cur_waddr_d    = cur_waddr_q;
        beat_cnt_d     = beat_cnt_q;
        ddr_we_d       = ddr_we_q;
        ddr_burstcnt_d = ddr_burstcnt_q;
        ddr_addr_d     = ddr_addr_q;
        ddr_din_d      = ddr_din_q;
        frame_done_d   = 1'b0;
        sof_err_d      = sof_err_q;
        push           = 1'b0;
        pop            = 1'b0;
        push_word      = '0;

        // Pixel intake: discard until the first sof, then pair pixels into words.
        if (pix_valid && pix_ready_q && (synced_q || pix_sof)) begin
            synced_d = 1'b1;
            if (synced_q && pix_sof && (pix_cnt_q != '0)) begin
                sof_err_d = 1'b1;
            end
            pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
            if (half_vld_q) begin
                push       = 1'b1;
                push_word  = {pix_data, half_q};
                half_vld_d = 1'b0;
            end else begin
                half_d     = pix_data;
                half_vld_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (fifo_count_q >= BURST_C) begin
                    state_d        = S_BURST;
                    ddr_we_d       = 1'b1;
                    ddr_burstcnt_d = 8'(BURST);
                    ddr_addr_d     = cur_waddr_q;
                    ddr_din_d      = fifo_mem[rd_ptr_q];
                    beat_cnt_d     = '0;
                end
            end
            S_BURST: begin
                if (ddr_we_q && !ddr_busy) begin
                    pop      = 1'b1;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d    = S_IDLE;
                        ddr_we_d   = 1'b0;
                        beat_cnt_d = '0;
                        if (cur_waddr_q + 29'(BURST) == END_WADDR) begin
                            cur_waddr_d  = BASE_WADDR;
                            frame_done_d = 1'b1;
                        end else begin
                            cur_waddr_d = cur_waddr_q + 29'(BURST);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        ddr_din_d  = fifo_mem[rd_ptr_d];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        pix_ready_d = synced_d ? (fifo_count_d < DEPTH_C) : 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q        <= S_IDLE;
            synced_q       <= 1'b0;
            half_vld_q     <= 1'b0;
            half_q         <= '0;
            pix_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_count_q   <= '0;
            cur_waddr_q    <= BASE_WADDR;
            beat_cnt_q     <= '0;
            ddr_we_q       <= 1'b0;
            ddr_burstcnt_q <= '0;
            ddr_addr_q     <= BASE_WADDR;
            ddr_din_q      <= '0;
            frame_done_q   <= 1'b0;
            sof_err_q      <= 1'b0;
            pix_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            synced_q       <= synced_d;
            half_vld_q     <= half_vld_d;
            half_q         <= half_d;
            pix_cnt_q      <= pix_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_count_q   <= fifo_count_d;
            cur_waddr_q    <= cur_waddr_d;
            beat_cnt_q     <= beat_cnt_d;
            ddr_we_q       <= ddr_we_d;
            ddr_burstcnt_q <= ddr_burstcnt_d;
            ddr_addr_q     <= ddr_addr_d;
            ddr_din_q      <= ddr_din_d;
            frame_done_q   <= frame_done_d;
            sof_err_q      <= sof_err_d;
            pix_ready_q    <= pix_ready_d;
        end
    end

    assign pix_ready    = pix_ready_q;
    assign ddr_we       = ddr_we_q;
    assign ddr_burstcnt = ddr_burstcnt_q;
    assign ddr_addr     = ddr_addr_q;
    assign ddr_din      = ddr_din_q;
    assign ddr_be       = 8'hFF;
    assign frame_done   = frame_done_q;
    assign sof_err      = sof_err_q;

endmodule

// File: tb/tb_fb_ddram_writer.sv
// Directed bench for fb_ddram_writer: pixel packing, burst protocol, busy stalls,
// frame wrap, sof error and mid-burst reset.
`timescale 1ns/1ps
module tb_fb_ddram_writer;

    // Reduced frame size keeps the run short; address expectations derive from it.
    localparam int unsigned FW        = 256;
    localparam logic [28:0] BASE      = 29'h0600_0000;
    localparam logic [28:0] LAST_ADDR = 29'h0600_00F8;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        ddr_busy;
    logic [7:0]  ddr_burstcnt;
    logic [28:0] ddr_addr;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_we;
    logic        frame_done;
    logic        sof_err;

    fb_ddram_writer #(
        .BASE_WADDR (BASE),
        .FRAME_WORDS(FW),
        .BURST      (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .ddr_busy    (ddr_busy),
        .ddr_burstcnt(ddr_burstcnt),
        .ddr_addr    (ddr_addr),
        .ddr_din     (ddr_din),
        .ddr_be      (ddr_be),
        .ddr_we      (ddr_we),
        .frame_done  (frame_done),
        .sof_err     (sof_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Beat monitor and protocol watcher
    int          beats = 0, proto_err = 0, fd_cnt = 0, busy_we = 0, bib = 0;
    logic [63:0] beat_q[$];
    logic [28:0] addr_q[$];
    logic [28:0] burst_addr = '0;
    logic        prev_rst = 1'b1, prev_we = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
    logic [28:0] prev_addr = '0;
    logic [63:0] prev_din = '0;
    logic [7:0]  prev_bc = '0;

    always @(negedge clk_sys) begin
        if (!prev_rst) begin
            if (prev_we && prev_busy &&
                (ddr_we !== 1'b1 || ddr_addr !== prev_addr || ddr_din !== prev_din || ddr_burstcnt !== prev_bc))
                proto_err++;
            if (bib != 0 && ddr_we !== 1'b1) proto_err++;
            if (prev_last && ddr_we === 1'b1) proto_err++;
        end
        if (ddr_be !== 8'hFF) proto_err++;
        if (ddr_we === 1'b1 && ddr_burstcnt !== 8'd8) proto_err++;
        if (!rst && ddr_we && ddr_busy) busy_we++;
        prev_last = 1'b0;
        if (!rst && ddr_we && !ddr_busy) begin
            if (bib == 0) begin
                burst_addr = ddr_addr;
                addr_q.push_back(ddr_addr);
            end else if (ddr_addr !== burst_addr) begin
                proto_err++;
            end
            beat_q.push_back(ddr_din);
            beats++;
            bib++;
            if (bib == 8) begin
                bib = 0;
                prev_last = 1'b1;
            end
        end
        if (rst) bib = 0;
        if (frame_done === 1'b1) fd_cnt++;
        prev_rst  = rst;
        prev_we   = ddr_we;
        prev_busy = ddr_busy;
        prev_addr = ddr_addr;
        prev_din  = ddr_din;
        prev_bc   = ddr_burstcnt;
    end

    // Busy driver: 0 idle, 1 held, 2 random, 3 single 5-cycle stall at beat stall_at
    int busy_mode = 0, stall_at = 0, stall_left = 0;
    bit stall_done = 1'b0;
    initial begin
        ddr_busy = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            case (busy_mode)
                1: ddr_busy = 1'b1;
                2: ddr_busy = ($urandom_range(0, 3) == 0);
                3: begin
                    if (stall_left > 0) begin
                        ddr_busy = 1'b1;
                        stall_left--;
                    end else if (!stall_done && beats == stall_at && ddr_we) begin
                        ddr_busy   = 1'b1;
                        stall_left = 4;
                        stall_done = 1'b1;
                    end else begin
                        ddr_busy = 1'b0;
                    end
                end
                default: ddr_busy = 1'b0;
            endcase
        end
    end

    // Expected kept pixels since the last sync
    logic [31:0] pix_m[$];
    bit          tb_synced = 1'b0;

    task automatic keep_pix(input logic [31:0] d, input logic sof);
        if (tb_synced || sof) begin
            tb_synced = 1'b1;
            pix_m.push_back(d);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
    task automatic send_pix(input logic [31:0] d, input logic sof);
        int to = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        @(negedge clk_sys);
        while (!pix_ready && to < 2000) begin
            @(negedge clk_sys);
            to++;
        end
        if (to >= 2000) chk("pix_accept_timeout", 64'(to), 64'(0));
        @(posedge clk_sys); #1;
        keep_pix(d, sof);
    endtask

    task automatic idle_pix();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int target);
        int t = 0;
        while (beats < target && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        repeat (12) @(negedge clk_sys);
        chk(tag, 64'(beats), 64'(target));
        @(posedge clk_sys); #1;
    endtask

    function automatic logic [63:0] exp_word(input int k);
        return {pix_m[2*k+1], pix_m[2*k]};
    endfunction

    initial begin
        int acc, errs, t;
        bit stop;
        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;
        @(negedge clk_sys);
        chk("rst_pix_ready",  64'(pix_ready),    64'(1));
        chk("rst_ddr_we",     64'(ddr_we),       64'(0));
        chk("rst_burstcnt",   64'(ddr_burstcnt), 64'(0));
        chk("rst_ddr_addr",   64'(ddr_addr),     64'(BASE));
        chk("rst_frame_done", 64'(frame_done),   64'(0));
        chk("rst_sof_err",    64'(sof_err),      64'(0));
        chk("rst_ddr_be",     64'(ddr_be),       64'(8'hFF));
        @(posedge clk_sys); #1;

        // Unsynced pixels are dropped, then the first burst after sof
        for (int i = 0; i < 16; i++) send_pix(32'hDEAD_0000 + 32'(i), 1'b0);
        idle_pix();
        repeat (20) @(posedge clk_sys); #1;
        chk("unsynced_no_burst", 64'(beats), 64'(0));
        for (int i = 1; i <= 16; i++) send_pix(32'(i), i == 1);
        idle_pix();
        wait_beats("first_burst_beats", 8);
        chk("first_burst_addr", 64'(addr_q[0]), 64'(BASE));
        chk("first_beat0_din",  beat_q[0], 64'h00000002_00000001);
        chk("first_beat7_din",  beat_q[7], 64'h00000010_0000000F);

        // Five-cycle busy stall on beat 3 of the second burst
        stall_at = 11;
        busy_mode = 3;
        for (int i = 'h11; i <= 'h20; i++) send_pix(32'(i), 1'b0);
        idle_pix();
        wait_beats("stall_burst_beats", 16);
        busy_mode = 0;
        chk("stall_burst_addr", 64'(addr_q[1]), 64'(BASE + 29'd8));
        chk("stall_busy_cycles", 64'(busy_we), 64'(5));
        chk("stall_beat0_din", beat_q[8],  64'h00000012_00000011);
        chk("stall_beat3_din", beat_q[11], 64'h00000018_00000017);
        chk("stall_beat7_din", beat_q[15], 64'h00000020_0000001F);

        // Busy held: FIFO fills to 16 words and back-pressures the pixel stream
        busy_mode = 1;
        acc = 0;
        stop = 1'b0;
        while (!stop && acc < 40) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_data  = 32'h100 + 32'(acc);
            @(negedge clk_sys);
            if (pix_ready) begin
                @(posedge clk_sys); #1;
                keep_pix(pix_data, 1'b0);
                acc++;
            end else begin
                stop = 1'b1;
            end
        end
        chk("hold_pixels_before_stall", 64'(acc), 64'(32));
        repeat (5) @(negedge clk_sys);
        chk("hold_pix_ready_low", 64'(pix_ready), 64'(0));
        chk("hold_no_pops", 64'(beats), 64'(16));
        @(posedge clk_sys); #1;
        busy_mode = 0;
        for (int i = acc; i < 64; i++) send_pix(32'h100 + 32'(i), 1'b0);
        idle_pix();
        wait_beats("hold_release_beats", 48);
        chk("hold_first_word", beat_q[16], 64'h00000101_00000100);
        chk("hold_last_word",  beat_q[47], 64'h0000013F_0000013E);

        // Stray sof on pixel 100, then run to the end of the frame
        for (int i = 96; i < 512; i++) send_pix(32'h2000_0000 + 32'(i), i == 100);
        idle_pix();
        wait_beats("frame1_beats", 256);
        chk("sof_err_set", 64'(sof_err), 64'(1));
        chk("frame1_done_pulses", 64'(fd_cnt), 64'(1));
        chk("frame1_bursts", 64'(addr_q.size()), 64'(32));
        chk("frame1_last_addr", 64'(addr_q[31]), 64'(LAST_ADDR));

        // Full frame with random busy
        busy_mode = 2;
        for (int i = 0; i < 512; i++) send_pix(32'h3000_0000 + 32'(i), i == 0);
        idle_pix();
        wait_beats("frame2_beats", 512);
        busy_mode = 0;
        chk("frame2_done_pulses", 64'(fd_cnt), 64'(2));
        chk("frame2_bursts", 64'(addr_q.size()), 64'(64));
        chk("frame2_first_addr", 64'(addr_q[32]), 64'(BASE));
        chk("frame2_last_addr", 64'(addr_q[63]), 64'(LAST_ADDR));
        chk("sof_err_sticky", 64'(sof_err), 64'(1));
        errs = 0;
        for (int k = 0; k < 64; k++)
            if (addr_q[k] !== BASE + 29'(8 * (k % 32))) errs++;
        chk("addr_sequence_errs", 64'(errs), 64'(0));
        errs = 0;
        for (int k = 0; k < 512; k++)
            if (beat_q[k] !== exp_word(k)) errs++;
        chk("data_scoreboard_errs", 64'(errs), 64'(0));

        // Reset on beat 4 of a burst
        for (int i = 0; i < 16; i++) send_pix(32'h4000_0000 + 32'(i), i == 0);
        idle_pix();
        t = 0;
        while (!(beats == 516 && ddr_we) && t < 200) begin
            @(posedge clk_sys); #1;
            t++;
        end
        chk("reach_beat4", 64'(beats), 64'(516));
        rst = 1'b1;
        @(negedge clk_sys);
        chk("rst_midburst_we_before_edge", 64'(ddr_we), 64'(1));
        @(negedge clk_sys);
        chk("rst_midburst_we_drop", 64'(ddr_we), 64'(0));
        @(posedge clk_sys); #1;
        rst = 1'b0;
        tb_synced = 1'b0;
        @(negedge clk_sys);
        chk("rst2_burstcnt",   64'(ddr_burstcnt), 64'(0));
        chk("rst2_ddr_addr",   64'(ddr_addr),     64'(BASE));
        chk("rst2_frame_done", 64'(frame_done),   64'(0));
        chk("rst2_sof_err",    64'(sof_err),      64'(0));
        chk("rst2_pix_ready",  64'(pix_ready),    64'(1));
        repeat (20) @(negedge clk_sys);
        chk("rst2_burst_abandoned", 64'(beats), 64'(516));
        @(posedge clk_sys); #1;
        for (int i = 0; i < 4; i++) send_pix(32'h5000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 16; i++) send_pix(32'h6000_0000 + 32'(i), i == 0);
        idle_pix();
        wait_beats("post_rst_beats", 524);
        chk("post_rst_addr", 64'(addr_q[65]), 64'(BASE));
        chk("post_rst_beat0", beat_q[516], 64'h60000001_60000000);
        chk("post_rst_beat7", beat_q[523], 64'h6000000F_6000000E);
        chk("protocol_errs", 64'(proto_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
